// File: rtl/p256_pkg.sv
// Shared definitions for the P-256 modular multiplier: the prime, the
// controller state encoding and the operand-width legality check.
package p256_pkg;

    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_WAIT,
        LOAD_CAP,
        MUL_START,
        MUL_WAIT,
        RED_START,
        RED_WAIT,
        WRITE,
        FINISH
    } state_t;

    // Word width must be 32 or 64 and the words must tile exactly 256 bits.
    function automatic bit widthsLegal(input int dw, input int nw);
        return ((dw == 32) || (dw == 64)) && ((dw * nw) == 256);
    endfunction

endpackage

// File: rtl/P_256_Reducer.sv
// Bit-serial reduction of a 512-bit value modulo the P-256 prime; the
// remainder stays below p at every step, so the result is fully reduced.
module P_256_Reducer
    import p256_pkg::*;
(
    input  logic [511:0] in,
    input  logic         clk,
    input  logic         rst_n,
    output logic         done,
    output logic [255:0] out
);

    logic [255:0] rem_q;
    logic [9:0]   cnt_q;
    logic [8:0]   bitIdx;
    logic [256:0] dbl;
    logic [256:0] diff;

    assign bitIdx = ~cnt_q[8:0];
    assign dbl    = {rem_q, in[bitIdx]};
    assign diff   = dbl - {1'b0, P256};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            cnt_q <= '0;
        end else if (cnt_q != 10'd512) begin
            rem_q <= (dbl >= {1'b0, P256}) ? diff[255:0] : dbl[255:0];
            cnt_q <= cnt_q + 10'd1;
        end
    end

    assign done = (cnt_q == 10'd512);
    assign out  = rem_q;

endmodule

// File: rtl/Rad4_mul_256.sv
// Sequential radix-4 256x256 multiplier: consumes two bits of y per cycle,
// MSB first, and raises done (held) once the full 512-bit product is ready.
module Rad4_mul_256 (
    input  logic [255:0] x,
    input  logic [255:0] y,
    input  logic         clk,
    input  logic         rst_n,
    output logic         done,
    output logic [255:0] out_low,
    output logic [255:0] out_high
);

    logic [511:0] acc_q;
    logic [7:0]   cnt_q;
    logic [7:0]   digitIdx;
    logic [1:0]   digit;
    logic [257:0] partial;

    assign digitIdx = {7'd127 - cnt_q[6:0], 1'b0};
    assign digit    = y[digitIdx +: 2];

    always_comb begin
        partial = '0;
        case (digit)
            2'd1:    partial = {2'b00, x};
            2'd2:    partial = {1'b0, x, 1'b0};
            2'd3:    partial = {2'b00, x} + {1'b0, x, 1'b0};
            default: partial = '0;
        endcase
    end

    // Horner accumulation: acc = acc*4 + x*digit, 128 steps then stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (cnt_q != 8'd128) begin
            acc_q <= {acc_q[509:0], 2'b00} + {254'b0, partial};
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign done     = (cnt_q == 8'd128);
    assign out_low  = acc_q[255:0];
    assign out_high = acc_q[511:256];

endmodule

// File: rtl/p256_modmul_seq.sv
// P-256 modular multiply/square controller: loads operands word by word,
// runs the multiplier and reducer, then streams the result out word by word.
module p256_modmul_seq
    import p256_pkg::*;
#(
    parameter  int DW     = 32,
    parameter  int NW     = 256 / DW,
    parameter  int RD_LAT = 3,
    localparam int AW     = $clog2(NW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          start,
    input  logic          mode,
    input  logic [DW-1:0] a_din,
    input  logic [DW-1:0] b_din,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] d_addr,
    output logic          d_wren,
    output logic [DW-1:0] d_dout
);

    if (!widthsLegal(DW, NW)) begin : gen_bad_width
        $error("p256_modmul_seq: DW must be 32 or 64 with DW*NW == 256");
    end
    if ((RD_LAT < 1) || (RD_LAT > 7)) begin : gen_bad_lat
        $error("p256_modmul_seq: RD_LAT must be in 1..7");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [2:0]    lat_q, lat_d;
    logic          mode_q, mode_d;
    logic [255:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [511:0]  prod_q, prod_d;
    logic          busy_q, busy_d, done_q, done_d, wren_q, wren_d;
    logic [AW-1:0] daddr_q, daddr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          mulRstN_q, redRstN_q;
    logic          mulRstN, redRstN, mulDone, redDone;
    logic [255:0]  mulLow, mulHigh, redOut, mulY;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lat_d   = lat_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wren_d  = 1'b0;
        daddr_d = daddr_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    k_d     = '0;
                    lat_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (lat_q == 3'(RD_LAT - 1)) state_d = LOAD_CAP;
                else                         lat_d   = lat_q + 3'd1;
            end
            LOAD_CAP: begin
                a_d[k_q*DW +: DW] = a_din;
                if (mode_q) b_d[k_q*DW +: DW] = b_din;
                k_d     = k_q + 1'b1;
                lat_d   = '0;
                state_d = (k_q == AW'(NW - 1)) ? MUL_START : LOAD_WAIT;
            end
            MUL_START: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mulDone) begin
                    prod_d  = {mulHigh, mulLow};
                    state_d = RED_START;
                end
            end
            RED_START: state_d = RED_WAIT;
            RED_WAIT: begin
                if (redDone) begin
                    res_d   = redOut;
                    k_d     = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wren_d  = 1'b1;
                daddr_d = k_q;
                dout_d  = res_q[k_q*DW +: DW];
                k_d     = k_q + 1'b1;
                if (k_q == AW'(NW - 1)) state_d = FINISH;
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All controller state and outputs advance only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            lat_q   <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wren_q  <= 1'b0;
            daddr_q <= '0;
            dout_q  <= '0;
        end else if (ena) begin
            state_q <= state_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wren_q  <= wren_d;
            daddr_q <= daddr_d;
            dout_q  <= dout_d;
        end
    end

    // Registered restart pulses keep the sub-module resets glitch-free; they
    // fire in the enabled cycle that leaves the matching START state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mulRstN_q <= 1'b1;
            redRstN_q <= 1'b1;
        end else begin
            mulRstN_q <= !(ena && (state_q == MUL_START));
            redRstN_q <= !(ena && (state_q == RED_START));
        end
    end

    assign mulRstN = rst_n & mulRstN_q;
    assign redRstN = rst_n & redRstN_q;
    assign mulY    = mode_q ? b_q : a_q;

    Rad4_mul_256 u_mul (
        .x        (a_q),
        .y        (mulY),
        .clk      (clk),
        .rst_n    (mulRstN),
        .done     (mulDone),
        .out_low  (mulLow),
        .out_high (mulHigh)
    );

    P_256_Reducer u_red (
        .in    (prod_q),
        .clk   (clk),
        .rst_n (redRstN),
        .done  (redDone),
        .out   (redOut)
    );

    assign a_addr = k_q;
    assign b_addr = k_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign d_addr = daddr_q;
    assign d_wren = wren_q;
    assign d_dout = dout_q;

endmodule

// File: tb/tb_p256_modmul_seq.sv
// Self-checking bench for p256_modmul_seq: a 32-bit/RD_LAT=3 instance and a
// 64-bit/RD_LAT=1 instance, checked against (a*b) mod p computed directly.
module tb_p256_modmul_seq;

    localparam logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [255:0] TWO256_MOD_P =
        256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        ena32, start32, mode32, busy32, done32, dWren32;
    logic [31:0] aDin32, bDin32, dDout32;
    logic [2:0]  aAddr32, bAddr32, dAddr32;

    logic        ena64, start64, mode64, busy64, done64, dWren64;
    logic [63:0] aDin64, bDin64, dDout64;
    logic [1:0]  aAddr64, bAddr64, dAddr64;

    p256_modmul_seq #(.DW(32), .RD_LAT(3)) dut32 (
        .clk(clk), .rst_n(rst_n), .ena(ena32), .start(start32), .mode(mode32),
        .a_din(aDin32), .b_din(bDin32), .a_addr(aAddr32), .b_addr(bAddr32),
        .busy(busy32), .done(done32), .d_addr(dAddr32), .d_wren(dWren32), .d_dout(dDout32)
    );

    p256_modmul_seq #(.DW(64), .RD_LAT(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .ena(ena64), .start(start64), .mode(mode64),
        .a_din(aDin64), .b_din(bDin64), .a_addr(aAddr64), .b_addr(bAddr64),
        .busy(busy64), .done(done64), .d_addr(dAddr64), .d_wren(dWren64), .d_dout(dDout64)
    );

    // Operand memories with a fixed read-latency pipeline behind each port.
    logic [255:0] memA32, memB32, memA64;
    logic [31:0]  aPipe32 [3];
    logic [31:0]  bPipe32 [3];
    logic [63:0]  aPipe64;

    always @(posedge clk) begin
        aPipe32[0] <= memA32[aAddr32*32 +: 32];
        bPipe32[0] <= memB32[bAddr32*32 +: 32];
        for (int i = 1; i < 3; i++) begin
            aPipe32[i] <= aPipe32[i-1];
            bPipe32[i] <= bPipe32[i-1];
        end
        aPipe64 <= memA64[aAddr64*64 +: 64];
    end
    assign aDin32 = aPipe32[2];
    assign bDin32 = bPipe32[2];
    assign aDin64 = aPipe64;
    assign bDin64 = 64'h0;

    // Result-port monitors: a write or done counts once per enabled cycle.
    logic [34:0] wrQ32 [$];
    logic [65:0] wrQ64 [$];
    int dn32 = 0;
    int dn64 = 0;

    always @(negedge clk) begin
        if (rst_n && ena32) begin
            if (dWren32) wrQ32.push_back({dAddr32, dDout32});
            if (done32) dn32++;
        end
        if (rst_n && ena64) begin
            if (dWren64) wrQ64.push_back({dAddr64, dDout64});
            if (done64) dn64++;
        end
    end

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] refModMul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] prod;
        prod = {256'b0, a} * {256'b0, b};
        return 256'(prod % {256'b0, P});
    endfunction

    function automatic logic [255:0] randWide();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic applyStimulus(input logic [255:0] a, input logic [255:0] b, input logic m,
                                 input bit toggleEna, input bit extraStart,
                                 input logic [255:0] expected, input string tag);
        int baseW, baseD, cyc, enCyc, loadLen, nW, addrBad;
        logic [2:0]   prevAddr;
        bit           loadSeen;
        logic [255:0] got;
        logic [34:0]  e;
        memA32 = a;
        memB32 = b;
        baseW  = wrQ32.size();
        baseD  = dn32;
        @(posedge clk); #1;
        ena32 = 1'b1; start32 = 1'b1; mode32 = m;
        @(posedge clk); #1;
        start32 = 1'b0;
        enCyc = 0; loadLen = 0; prevAddr = 3'd0; loadSeen = 1'b0; cyc = 0;
        while ((dn32 == baseD) && (cyc < 20000)) begin
            ena32   = toggleEna ? ~ena32 : 1'b1;
            start32 = (extraStart && (cyc == 10));
            mode32  = ~m;
            @(posedge clk);
            if (ena32) enCyc++;
            #1;
            if (!loadSeen && (prevAddr == 3'd7) && (aAddr32 == 3'd0)) begin
                loadSeen = 1'b1;
                loadLen  = enCyc;
            end
            prevAddr = aAddr32;
            cyc++;
        end
        ena32 = 1'b1; start32 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        nW = wrQ32.size() - baseW;
        got = '0; addrBad = 0;
        for (int i = 0; (i < nW) && (i < 8); i++) begin
            e = wrQ32[baseW + i];
            got[i*32 +: 32] = e[31:0];
            if (e[34:32] != 3'(i)) addrBad++;
        end
        checkOutput({tag, ".result"},  got, expected);
        checkOutput({tag, ".writes"},  256'(nW), 256'd8);
        checkOutput({tag, ".done"},    256'(dn32 - baseD), 256'd1);
        checkOutput({tag, ".addrSeq"}, 256'(addrBad), 256'd0);
        checkOutput({tag, ".busyEnd"}, 256'(busy32), 256'd0);
        if (toggleEna) checkOutput({tag, ".loadCycles"}, 256'(loadLen), 256'd32);
    endtask

    task automatic checkOutput64(input logic [255:0] a, input logic [255:0] expected, input string tag);
        int baseW, baseD, cyc, nW, addrBad;
        logic [255:0] got;
        logic [65:0]  e;
        memA64 = a;
        baseW  = wrQ64.size();
        baseD  = dn64;
        @(posedge clk); #1;
        start64 = 1'b1; mode64 = 1'b0;
        @(posedge clk); #1;
        start64 = 1'b0;
        cyc = 0;
        while ((dn64 == baseD) && (cyc < 20000)) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        nW = wrQ64.size() - baseW;
        got = '0; addrBad = 0;
        for (int i = 0; (i < nW) && (i < 4); i++) begin
            e = wrQ64[baseW + i];
            got[i*64 +: 64] = e[63:0];
            if (e[65:64] != 2'(i)) addrBad++;
        end
        checkOutput({tag, ".result"},  got, expected);
        checkOutput({tag, ".writes"},  256'(nW), 256'd4);
        checkOutput({tag, ".done"},    256'(dn64 - baseD), 256'd1);
        checkOutput({tag, ".addrSeq"}, 256'(addrBad), 256'd0);
    endtask

    initial begin
        logic [255:0] ra, rb;
        rst_n = 1'b0;
        ena32 = 1'b1; start32 = 1'b0; mode32 = 1'b0;
        ena64 = 1'b1; start64 = 1'b0; mode64 = 1'b0;
        memA32 = '0; memB32 = '0; memA64 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset32", 256'({busy32, done32, dWren32, aAddr32, bAddr32, dAddr32, dDout32}), 256'd0);
        checkOutput("reset64", 256'({busy64, done64, dWren64, aAddr64, bAddr64, dAddr64, dDout64}), 256'd0);
        rst_n = 1'b1;

        applyStimulus(256'd1, 256'd0, 1'b0, 1'b0, 1'b0, 256'd1, "sqOne");
        applyStimulus(P - 256'd1, randWide(), 1'b0, 1'b0, 1'b0, 256'd1, "sqPm1");
        applyStimulus(256'd2, 256'd3, 1'b1, 1'b0, 1'b1, 256'd6, "mul2x3");
        applyStimulus(P - 256'd2, 256'd2, 1'b1, 1'b1, 1'b0, P - 256'd4, "enaToggle");

        // Reset while the multiplier is running.
        memA32 = randWide(); memB32 = randWide();
        @(posedge clk); #1;
        ena32 = 1'b1; start32 = 1'b1; mode32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (45) @(posedge clk);
        #2;
        checkOutput("midBusy", 256'(busy32), 256'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetCtl",  256'({busy32, done32, dWren32}), 256'd0);
        checkOutput("midResetAddr", 256'({aAddr32, bAddr32, dAddr32}), 256'd0);
        checkOutput("midResetData", 256'(dDout32), 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ra = randWide(); rb = randWide();
        applyStimulus(ra, rb, 1'b1, 1'b0, 1'b0, refModMul(ra, rb), "afterReset");

        for (int i = 0; i < 3; i++) begin
            ra = randWide(); rb = randWide();
            applyStimulus(ra, rb, 1'b1, ($urandom_range(0, 1) == 1), 1'b0, refModMul(ra, rb), "randMul");
            ra = randWide();
            applyStimulus(ra, randWide(), 1'b0, 1'b0, 1'b0, refModMul(ra, ra), "randSq");
        end

        checkOutput64(256'd1 << 128, TWO256_MOD_P, "dw64pow");
        ra = randWide();
        checkOutput64(ra, refModMul(ra, ra), "dw64rand");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/p256_modmul_seq.md
P256_MODMUL_SEQ -- requirements
Module: p256_modmul_seq

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result word width; legal values 32 or 64.
REQ-002 SHALL have parameter NW, default 256/DW, words per 256-bit operand; DW*NW != 256 is an elaboration error.
REQ-003 SHALL have parameter RD_LAT, default 3, cycles from address change to valid read data; legal range 1..7.
REQ-004 SHALL have derived localparam AW = clog2(NW).
REQ-005 SHALL have ports, one per line: name, direction, width, meaning:
 clk  input  1  single clock, rising edge
 rst_n  input  1  asynchronous active-low reset
 ena  input  1  clock enable; low freezes all state and outputs
 start  input  1  one-cycle request to begin an operation
 mode  input  1  0 = square (a*a mod p), 1 = multiply (a*b mod p); sampled with start
 a_din  input  DW  operand A read data
 b_din  input  DW  operand B read data, ignored when mode = 0
 a_addr  output  AW  operand A word address
 b_addr  output  AW  operand B word address
 busy  output  1  high from accepted start until done
 done  output  1  one-cycle pulse after the last result word is written
 d_addr  output  AW  result word address
 d_wren  output  1  result write strobe
 d_dout  output  DW  result write data

Function
REQ-006 SHALL implement states IDLE, LOAD_WAIT, LOAD_CAP, MUL_START, MUL_WAIT, RED_START, RED_WAIT, WRITE, FINISH.
REQ-007 SHALL, in IDLE with ena=1 and start=1, latch mode, clear the word counter to 0, assert busy, and enter LOAD_WAIT.
REQ-008 SHALL stay in LOAD_WAIT for exactly RD_LAT enabled cycles, then enter LOAD_CAP.
REQ-009 SHALL, in LOAD_CAP, write a_din into bits [k*DW +: DW] of the A register (and b_din into B when mode=1), where k is the word counter, then increment k; return to LOAD_WAIT if k < NW-1, else enter MUL_START.
REQ-010 SHALL drive a_addr = b_addr = k throughout loading; the operand load therefore takes NW*(RD_LAT+1) enabled cycles.
REQ-011 SHALL present A to both multiplier inputs when mode=0, and A and B when mode=1.
REQ-012 SHALL, in MUL_START, restart the multiplier with a one-cycle active-low pulse on its rst_n and enter MUL_WAIT; in MUL_WAIT, when done=1, capture the 512-bit product and enter RED_START.
REQ-013 SHALL, in RED_START, restart the reducer with a one-cycle pulse; in RED_WAIT, when done=1, capture the 256-bit result (fully reduced, < p) and enter WRITE with k=0.
REQ-014 SHALL, in WRITE, assert d_wren for one cycle per word with d_addr=k and d_dout = result[k*DW +: DW], for k = 0..NW-1 on consecutive enabled cycles, then enter FINISH.
REQ-015 SHALL, in FINISH, pulse done for one cycle, deassert busy, and return to IDLE; start in the same cycle is ignored.
REQ-016 SHALL ignore start whenever busy=1.
REQ-017 SHALL, when ena=0, hold state, counters, and all outputs; d_wren held high stays high, with no extra write implied on resume.
REQ-018 SHALL not wait on sub-module done while ena=0; sub-modules run on clk regardless of ena.

Reset
REQ-019 SHALL, on rst_n low at any time including mid-operation, asynchronously enter IDLE with k=0, busy=0, done=0, d_wren=0, a_addr=b_addr=d_addr=0, and d_dout=0.
REQ-020 SHALL hold the sub-module rst_n inactive-high while idle, and reset the sub-modules when the top rst_n is low.
REQ-021 SHALL clear operand and result registers to 0 on reset; no X values are driven.

Structure
REQ-022 SHALL place the P-256 prime constant, state encoding, and the DW/NW legality check in shared package p256_pkg.
REQ-023 SHALL instantiate the existing Rad4_mul_256 multiplier (x, y, clk, rst_n, done, out_low, out_high) and one P_256_Reducer sub-module (in[511:0], clk, rst_n, done, out[255:0]).

Verification
REQ-024 Bench SHALL cover, with DW=32 and RD_LAT=3: mode=0 with A=1 -> words 0..7 written as 0x00000001, 0, 0, 0, 0, 0, 0, 0; done pulses once.
REQ-025 Bench SHALL cover mode=0 with A=p-1 -> result 1, because (-1)^2 = 1 mod p.
REQ-026 Bench SHALL cover mode=1 with A=2 and B=3 -> result 6; a second start during busy is ignored, giving exactly 8 writes and 1 done.
REQ-027 Bench SHALL cover ena toggling 0/1 on alternate cycles throughout a mode=1 run with A=p-2 and B=2 -> result p-4, and load phase = 32 enabled cycles.
REQ-028 Bench SHALL cover rst_n asserted during MUL_WAIT -> outputs reach reset values immediately; a new start then yields the correct result for new operands.
REQ-029 Bench SHALL cover DW=64 (NW=4) with RD_LAT=1 in mode=0 with A=2^128 -> result equals 2^256 mod p = 0x00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000001, written in 4 words.
